zion_basic_circuit_lib_line_serializer: RTL and testbench

Sequencing controller for the word-select read datapath. It accepts one wide data line with a start word index and word count over a valid/ready handshake. It then steps the read address through the requested words, presenting one word per output beat on a second valid/ready handshake. It sits between a wide-line source, such as a buffer or memory read port, and a narrow word consumer.

---
 rtl/zion_basic_circuit_lib_line_serializer.sv | 115 +++++++++++
 tb/tb_zion_basic_circuit_lib_line_serializer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zion_basic_circuit_lib_line_serializer.sv
// Serializes one wide line into a run of words starting at iStart, wrapping modulo WORD_NUM.
// Latency: first word valid the cycle after accept; one word per cycle while iRdy is high.
// Backpressure: iRdy=0 holds oDat/oIdx/oLast. ZION_LINE_SERIALIZER_PREFETCH_EN lets the next line load on the last beat.
module zion_basic_circuit_lib_line_serializer #(
    parameter  int WIDTH_LINE = 256,
    parameter  int WIDTH_WORD = 32,
    localparam int WORD_NUM   = WIDTH_LINE / WIDTH_WORD,
    localparam int WIDTH_IDX  = $clog2(WORD_NUM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iClr,
    input  logic                  iVld,
    output logic                  oRdy,
    input  logic [WIDTH_LINE-1:0] iLine,
    input  logic [WIDTH_IDX-1:0]  iStart,
    input  logic [WIDTH_IDX:0]    iLen,
    output logic                  oVld,
    input  logic                  iRdy,
    output logic [WIDTH_WORD-1:0] oDat,
    output logic [WIDTH_IDX-1:0]  oIdx,
    output logic                  oLast
);

    localparam logic [WIDTH_IDX:0] LP_WORD_NUM = (WIDTH_IDX+1)'(WORD_NUM);
    localparam logic [WIDTH_IDX:0] LP_ONE      = (WIDTH_IDX+1)'(1);
    localparam logic [WIDTH_IDX:0] LP_TWO      = (WIDTH_IDX+1)'(2);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [WIDTH_LINE-1:0] r_line,  w_line_nxt;
    logic [WIDTH_IDX-1:0]  r_idx,   w_idx_nxt;
    logic [WIDTH_IDX:0]    r_rem,   w_rem_nxt;
    logic [WIDTH_WORD-1:0] r_dat,   w_dat_nxt;
    logic                  r_last,  w_last_nxt;

    logic                  w_acc;
    logic                  w_beat;
    logic [WIDTH_IDX:0]    w_len;
    logic [WIDTH_IDX-1:0]  w_idx_inc;

    assign oVld  = (r_state == BUSY);
    assign oDat  = r_dat;
    assign oIdx  = r_idx;
    assign oLast = r_last;

    always_comb begin
        oRdy = (r_state == IDLE);
`ifdef ZION_LINE_SERIALIZER_PREFETCH_EN
        // The next line may only slip in on the beat that retires the current one.
        if (r_state == BUSY) oRdy = r_last && iRdy;
`endif
    end

    assign w_acc     = iVld && oRdy;
    assign w_beat    = oVld && iRdy;
    assign w_len     = (iLen > LP_WORD_NUM) ? LP_WORD_NUM : iLen;
    assign w_idx_inc = r_idx + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_line_nxt  = r_line;
        w_idx_nxt   = r_idx;
        w_rem_nxt   = r_rem;
        w_dat_nxt   = r_dat;
        w_last_nxt  = r_last;
        if (iClr) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
            w_rem_nxt   = '0;
            w_dat_nxt   = '0;
            w_last_nxt  = 1'b0;
        end else if (w_acc) begin
            // In prefetch mode an accept in BUSY coincides with the last beat, so loading wins.
            w_line_nxt  = iLine;
            w_idx_nxt   = iStart;
            w_rem_nxt   = w_len;
            w_dat_nxt   = iLine[iStart*WIDTH_WORD +: WIDTH_WORD];
            w_last_nxt  = (w_len == LP_ONE);
            w_state_nxt = (w_len == '0) ? IDLE : BUSY;
        end else if (w_beat) begin
            if (r_last) begin
                w_state_nxt = IDLE;
            end else begin
                w_idx_nxt  = w_idx_inc;
                w_rem_nxt  = r_rem - LP_ONE;
                w_dat_nxt  = r_line[w_idx_inc*WIDTH_WORD +: WIDTH_WORD];
                w_last_nxt = (r_rem == LP_TWO);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_line  <= '0;
            r_idx   <= '0;
            r_rem   <= '0;
            r_dat   <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_line  <= w_line_nxt;
            r_idx   <= w_idx_nxt;
            r_rem   <= w_rem_nxt;
            r_dat   <= w_dat_nxt;
            r_last  <= w_last_nxt;
        end
    end

endmodule

// File: tb/tb_zion_basic_circuit_lib_line_serializer.sv
// Scoreboard bench: accepted lines expand into expected words; a negedge monitor checks each beat.
module tb_zion_basic_circuit_lib_line_serializer;

    localparam int WL = 256;
    localparam int WW = 32;
    localparam int WN = WL / WW;
    localparam int WI = $clog2(WN);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          iClr = 1'b0;
    logic          iVld = 1'b0;
    logic          oRdy;
    logic [WL-1:0] iLine = '0;
    logic [WI-1:0] iStart = '0;
    logic [WI:0]   iLen = '0;
    logic          oVld;
    logic          iRdy = 1'b0;
    logic [WW-1:0] oDat;
    logic [WI-1:0] oIdx;
    logic          oLast;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [WW-1:0] dat;
        logic [WI-1:0] idx;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t stall_v;
    bit   stall_p = 1'b0;
    bit   rnd_rdy = 1'b0;
    logic fixed_rdy = 1'b1;

    zion_basic_circuit_lib_line_serializer #(.WIDTH_LINE(WL), .WIDTH_WORD(WW)) dut (
        .clk(clk), .rst_n(rst_n), .iClr(iClr), .iVld(iVld), .oRdy(oRdy),
        .iLine(iLine), .iStart(iStart), .iLen(iLen), .oVld(oVld), .iRdy(iRdy),
        .oDat(oDat), .oIdx(oIdx), .oLast(oLast)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        iRdy = rnd_rdy ? 1'($urandom_range(0, 1)) : fixed_rdy;
    end

    // Reference: a line of length L from start S yields min(L,WN) words at (S+k) mod WN.
    function automatic void model_push(input logic [WL-1:0] line, input int start, input int len);
        int   n;
        int   i;
        exp_t e;
        n = (len > WN) ? WN : len;
        for (int k = 0; k < n; k++) begin
            i      = (start + k) % WN;
            e.dat  = line[i*WW +: WW];
            e.idx  = WI'(i);
            e.last = (k == n - 1);
            exp_q.push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n || iClr) begin
            exp_q.delete();
            stall_p = 1'b0;
        end else begin
            if (stall_p) begin
                checks++;
                if (!oVld || {oDat, oIdx, oLast} != stall_v) begin
                    errors++;
                    $display("FAIL stall_hold: got vld=%0d dat=%h idx=%0d last=%0d, expected vld=1 dat=%h idx=%0d last=%0d",
                             oVld, oDat, oIdx, oLast, stall_v.dat, stall_v.idx, stall_v.last);
                end
            end
            if (oVld && exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_beat: got oVld=1 idx=%0d, expected no output", oIdx);
            end else if (oVld && iRdy) begin
                mon_e = exp_q.pop_front();
                checks++;
                if ({oDat, oIdx, oLast} != mon_e) begin
                    errors++;
                    $display("FAIL beat: got dat=%h idx=%0d last=%0d, expected dat=%h idx=%0d last=%0d",
                             oDat, oIdx, oLast, mon_e.dat, mon_e.idx, mon_e.last);
                end
            end
            stall_p = oVld && !iRdy;
            stall_v = {oDat, oIdx, oLast};
            if (iVld && oRdy) model_push(iLine, int'(iStart), int'(iLen));
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WL-1:0] rand_line();
        logic [WL-1:0] l;
        for (int k = 0; k < WL / 32; k++) l[k*32 +: 32] = $urandom();
        return l;
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_line(input logic [WL-1:0] line, input int start, input int len);
        bit acc = 1'b0;
        int n   = 0;
        iLine  = line;
        iStart = WI'(start);
        iLen   = (WI+1)'(len);
        iVld   = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = oRdy;
            n++;
            @(posedge clk);
            #1;
        end
        iVld = 1'b0;
        if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((oVld || exp_q.size() != 0) && n < 300);
        if (n >= 300) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    logic [4:0] b2b_pat;
    logic       rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_oVld", 64'(oVld), 64'd0);
        chk("rst_oDat", 64'(oDat), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_oRdy", 64'(oRdy), 64'd1);
        chk("rel_oVld", 64'(oVld), 64'd0);
        chk("rel_oIdx", 64'(oIdx), 64'd0);
        chk("rel_oLast", 64'(oLast), 64'd0);
        @(posedge clk);
        #1;

        // Single line: words 2,3,4 right after accept, then ready again.
        send_line(rand_line(), 2, 3);
        @(negedge clk);
        chk("first_vld", 64'(oVld), 64'd1);
        chk("first_idx", 64'(oIdx), 64'd2);
        @(negedge clk);
        @(negedge clk);
        chk("third_last", 64'(oLast), 64'd1);
        @(negedge clk);
        chk("after_vld", 64'(oVld), 64'd0);
        chk("after_rdy", 64'(oRdy), 64'd1);
        @(posedge clk);
        #1;

        send_line(rand_line(), 6, 12);
        wait_idle();

        send_line(rand_line(), 0, 4);
        for (int i = 0; i < 4; i++) begin
            fixed_rdy = rdy_pat[i];
            @(posedge clk);
            #1;
        end
        fixed_rdy = 1'b1;
        wait_idle();

        send_line(rand_line(), 3, 0);
        repeat (3) begin
            @(negedge clk);
            chk("zero_len_vld", 64'(oVld), 64'd0);
        end
        @(posedge clk);
        #1;

        // Abort on the second beat, then a fresh line must start at its own index.
        send_line(rand_line(), 0, 4);
        @(posedge clk);
        #1;
        iClr = 1'b1;
        @(posedge clk);
        #1;
        iClr = 1'b0;
        @(negedge clk);
        chk("clr_vld", 64'(oVld), 64'd0);
        chk("clr_rdy", 64'(oRdy), 64'd1);
        @(posedge clk);
        #1;
        send_line(rand_line(), 5, 2);
        @(negedge clk);
        chk("post_clr_idx", 64'(oIdx), 64'd5);
        wait_idle();

        fork
            begin
                send_line(rand_line(), 1, 2);
                send_line(rand_line(), 4, 2);
            end
            begin
                int n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!oVld && n < 50);
                b2b_pat[4] = oVld;
                for (int k = 3; k >= 0; k--) begin
                    @(negedge clk);
                    b2b_pat[k] = oVld;
                end
            end
        join
`ifdef ZION_LINE_SERIALIZER_PREFETCH_EN
        chk("b2b_pattern", 64'(b2b_pat), 64'b11110);
`else
        chk("b2b_pattern", 64'(b2b_pat), 64'b11011);
`endif
        wait_idle();

        rnd_rdy = 1'b1;
        for (int t = 0; t < 40; t++) begin
            send_line(rand_line(), $urandom_range(0, WN - 1), $urandom_range(0, WN + 4));
        end
        wait_idle();
        rnd_rdy = 1'b0;

        // Asynchronous reset while stalled mid-line.
        fixed_rdy = 1'b0;
        send_line(rand_line(), 1, 4);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 64'(oVld), 64'd0);
        chk("arst_dat", 64'(oDat), 64'd0);
        chk("arst_idx", 64'(oIdx), 64'd0);
        chk("arst_last", 64'(oLast), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fixed_rdy = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("arst_no_beat", 64'(oVld), 64'd0);
        end

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
